// File: rtl/mips_store_pkg.sv
// Shared encodings for the store narrowing path: request sizes, FSM states,
// byte-enable patterns and the alignment rule.
package mips_store_pkg;

   localparam int unsigned DATA_W = 32;
   localparam int unsigned BEAT_W = 16;
   localparam int unsigned BE_W   = 2;

   typedef enum logic [1:0] {
      SZ_BYTE = 2'b00,
      SZ_HALF = 2'b01,
      SZ_WORD = 2'b10,
      SZ_RSVD = 2'b11
   } size_e;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_BEAT0 = 2'd1,
      ST_BEAT1 = 2'd2
   } state_e;

   // Bit 1 enables wdata[15:8], the even (big-endian first) byte.
   localparam logic [BE_W-1:0] BE_NONE = 2'b00;
   localparam logic [BE_W-1:0] BE_LO   = 2'b01;
   localparam logic [BE_W-1:0] BE_HI   = 2'b10;
   localparam logic [BE_W-1:0] BE_ALL  = 2'b11;

   // Reserved size is always rejected.
   function automatic logic is_misaligned(input size_e size, input logic [1:0] addr_lo);
      logic bad;
      case (size)
         SZ_BYTE: bad = 1'b0;
         SZ_HALF: bad = addr_lo[0];
         SZ_WORD: bad = (addr_lo != 2'b00);
         default: bad = 1'b1;
      endcase
      return bad;
   endfunction

endpackage

// File: rtl/store_lane_pack.sv
// Big-endian lane packer: maps register data onto one 16-bit write beat.
// Ports: size_i request size, addr0_i byte address bit 0, data_i register
// data, beat_i beat index (0 first, 1 second half of a word); wdata_o / be_o
// beat data and byte enables.
module store_lane_pack
   import mips_store_pkg::*;
(
   input  size_e                   size_i,
   input  logic                    addr0_i,
   input  logic [DATA_W-1:0]       data_i,
   input  logic                    beat_i,
   output logic [BEAT_W-1:0]       wdata_o,
   output logic [BE_W-1:0]         be_o
);

   always_comb begin
      wdata_o = '0;
      be_o    = BE_NONE;
      case (size_i)
         SZ_BYTE: begin
            // Byte replicated on both lanes; enable selects the target byte.
            wdata_o = {data_i[7:0], data_i[7:0]};
            be_o    = addr0_i ? BE_LO : BE_HI;
         end
         SZ_HALF: begin
            wdata_o = data_i[15:0];
            be_o    = BE_ALL;
         end
         SZ_WORD: begin
            wdata_o = beat_i ? data_i[15:0] : data_i[31:16];
            be_o    = BE_ALL;
         end
         default: begin
            wdata_o = '0;
            be_o    = BE_NONE;
         end
      endcase
   end

endmodule

// File: rtl/store_narrow_unit.sv
// Store narrowing unit: accepts one 32-bit store request, checks alignment,
// and issues one (byte/half) or two (word) big-endian halfword write beats.
// Ports: clk/rst (sync, active high); req_valid/req_ready/req_addr/req_data/
// req_size request side; mem_valid/mem_ready/mem_addr/mem_wdata/mem_be write
// port; done and misalign are single-cycle completion/reject pulses.
module store_narrow_unit
   import mips_store_pkg::*;
#(
   parameter int unsigned ADDR_W = 32
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              req_valid,
   output logic              req_ready,
   input  logic [ADDR_W-1:0] req_addr,
   input  logic [DATA_W-1:0] req_data,
   input  logic [1:0]        req_size,
   output logic              mem_valid,
   input  logic              mem_ready,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [BEAT_W-1:0] mem_wdata,
   output logic [BE_W-1:0]   mem_be,
   output logic              done,
   output logic              misalign
);

   state_e              state_q, state_d;
   size_e               size_q, size_d;
   logic [DATA_W-1:0]   data_q, data_d;
   logic                ready_q, ready_d;
   logic                valid_q, valid_d;
   logic [ADDR_W-1:0]   addr_q, addr_d;
   logic [BEAT_W-1:0]   wdata_q, wdata_d;
   logic [BE_W-1:0]     be_q, be_d;
   logic                done_q, done_d;
   logic                mis_q, mis_d;

   size_e               req_size_e;
   size_e               pk_size;
   logic [DATA_W-1:0]   pk_data;
   logic                pk_beat;
   logic [BEAT_W-1:0]   pk_wdata;
   logic [BE_W-1:0]     pk_be;

   assign req_size_e = size_e'(req_size);

   // Packer sees the incoming request in IDLE (first beat) and the latched
   // request afterwards (second word beat). addr0 only matters for bytes,
   // which are always packed from the live request.
   assign pk_size = (state_q == ST_IDLE) ? req_size_e : size_q;
   assign pk_data = (state_q == ST_IDLE) ? req_data : data_q;
   assign pk_beat = (state_q == ST_BEAT0);

   store_lane_pack u_pack (
      .size_i  (pk_size),
      .addr0_i (req_addr[0]),
      .data_i  (pk_data),
      .beat_i  (pk_beat),
      .wdata_o (pk_wdata),
      .be_o    (pk_be)
   );

   // State and registered outputs.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= ST_IDLE;
         size_q  <= SZ_BYTE;
         data_q  <= '0;
         ready_q <= 1'b1;
         valid_q <= 1'b0;
         addr_q  <= '0;
         wdata_q <= '0;
         be_q    <= BE_NONE;
         done_q  <= 1'b0;
         mis_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         size_q  <= size_d;
         data_q  <= data_d;
         ready_q <= ready_d;
         valid_q <= valid_d;
         addr_q  <= addr_d;
         wdata_q <= wdata_d;
         be_q    <= be_d;
         done_q  <= done_d;
         mis_q   <= mis_d;
      end
   end

   // Next state and next registered outputs.
   always_comb begin
      state_d = state_q;
      size_d  = size_q;
      data_d  = data_q;
      ready_d = ready_q;
      valid_d = valid_q;
      addr_d  = addr_q;
      wdata_d = wdata_q;
      be_d    = be_q;
      done_d  = 1'b0;
      mis_d   = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (req_valid) begin
               if (is_misaligned(req_size_e, req_addr[1:0])) begin
                  mis_d = 1'b1;
               end else begin
                  state_d = ST_BEAT0;
                  size_d  = req_size_e;
                  data_d  = req_data;
                  addr_d  = {req_addr[ADDR_W-1:1], 1'b0};
                  valid_d = 1'b1;
                  wdata_d = pk_wdata;
                  be_d    = pk_be;
                  ready_d = 1'b0;
               end
            end
         end
         ST_BEAT0: begin
            if (mem_ready) begin
               if (size_q == SZ_WORD) begin
                  // Word is aligned, so +2 is just setting bit 1.
                  state_d = ST_BEAT1;
                  addr_d  = {addr_q[ADDR_W-1:2], 2'b10};
                  wdata_d = pk_wdata;
                  be_d    = pk_be;
               end else begin
                  state_d = ST_IDLE;
                  valid_d = 1'b0;
                  wdata_d = '0;
                  be_d    = BE_NONE;
                  ready_d = 1'b1;
                  done_d  = 1'b1;
               end
            end
         end
         ST_BEAT1: begin
            if (mem_ready) begin
               state_d = ST_IDLE;
               valid_d = 1'b0;
               wdata_d = '0;
               be_d    = BE_NONE;
               ready_d = 1'b1;
               done_d  = 1'b1;
            end
         end
         default: begin
            state_d = ST_IDLE;
            valid_d = 1'b0;
            wdata_d = '0;
            be_d    = BE_NONE;
            ready_d = 1'b1;
         end
      endcase
   end

   assign req_ready = ready_q;
   assign mem_valid = valid_q;
   assign mem_addr  = addr_q;
   assign mem_wdata = wdata_q;
   assign mem_be    = be_q;
   assign done      = done_q;
   assign misalign  = mis_q;

endmodule

// File: tb/tb_store_narrow_unit.sv
// Bench for store_narrow_unit: directed test-plan cases with literal
// expectations, then randomized traffic, all checked every cycle against a
// queue-of-pending-beats model.
module tb_store_narrow_unit;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        req_valid = 1'b0;
   logic        req_ready;
   logic [31:0] req_addr = '0;
   logic [31:0] req_data = '0;
   logic [1:0]  req_size = '0;
   logic        mem_valid;
   logic        mem_ready = 1'b1;
   logic [31:0] mem_addr;
   logic [15:0] mem_wdata;
   logic [1:0]  mem_be;
   logic        done;
   logic        misalign;

   store_narrow_unit #(.ADDR_W(32)) dut (
      .clk       (clk),
      .rst       (rst),
      .req_valid (req_valid),
      .req_ready (req_ready),
      .req_addr  (req_addr),
      .req_data  (req_data),
      .req_size  (req_size),
      .mem_valid (mem_valid),
      .mem_ready (mem_ready),
      .mem_addr  (mem_addr),
      .mem_wdata (mem_wdata),
      .mem_be    (mem_be),
      .done      (done),
      .misalign  (misalign)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic [31:0] addr;
      logic [15:0] wdata;
      logic [1:0]  be;
   } beat_t;

   beat_t       mq[$];
   logic [31:0] m_addr = '0;
   logic        m_done = 1'b0;
   logic        m_mis  = 1'b0;
   bit          armed  = 1'b0;
   int          n_checks = 0;
   int          n_pass   = 0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
   endtask

   function automatic bit model_bad(input logic [1:0] size, input logic [31:0] a);
      return (size == 2'b11) || (size == 2'b01 && a[0]) || (size == 2'b10 && a[1:0] != 2'b00);
   endfunction

   // Compare the DUT to the model, then advance the model with the inputs
   // the DUT will sample at the next rising edge.
   always @(negedge clk) begin
      beat_t hd;
      beat_t nb;
      logic  busy;
      busy = (mq.size() != 0);
      hd   = busy ? mq[0] : '0;
      if (armed)
         chk("cycle {ready,valid,addr,wdata,be,done,mis}",
             {10'h0, req_ready, mem_valid, mem_addr, mem_wdata, mem_be, done, misalign},
             {10'h0, !busy, busy, m_addr, hd.wdata, hd.be, m_done, m_mis});
      if (rst) begin
         mq.delete();
         m_addr = '0;
         m_done = 1'b0;
         m_mis  = 1'b0;
         armed  = 1'b1;
      end else begin
         m_done = 1'b0;
         m_mis  = 1'b0;
         if (busy) begin
            if (mem_ready) begin
               void'(mq.pop_front());
               if (mq.size() == 0) m_done = 1'b1;
            end
         end else if (req_valid) begin
            if (model_bad(req_size, req_addr)) begin
               m_mis = 1'b1;
            end else if (req_size == 2'b00) begin
               nb.addr  = {req_addr[31:1], 1'b0};
               nb.wdata = {req_data[7:0], req_data[7:0]};
               nb.be    = req_addr[0] ? 2'b01 : 2'b10;
               mq.push_back(nb);
            end else if (req_size == 2'b01) begin
               nb.addr  = req_addr;
               nb.wdata = req_data[15:0];
               nb.be    = 2'b11;
               mq.push_back(nb);
            end else begin
               nb.addr  = req_addr;
               nb.wdata = req_data[31:16];
               nb.be    = 2'b11;
               mq.push_back(nb);
               nb.addr  = req_addr + 32'd2;
               nb.wdata = req_data[15:0];
               mq.push_back(nb);
            end
         end
         if (mq.size() != 0) m_addr = mq[0].addr;
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic v, input logic [1:0] sz, input logic [31:0] a, input logic [31:0] d);
      req_valid = v;
      req_size  = sz;
      req_addr  = a;
      req_data  = d;
   endtask

   logic [1:0]  mis_sz[3] = '{2'b10, 2'b01, 2'b11};
   logic [31:0] mis_ad[3] = '{32'h0000_4002, 32'h0000_4001, 32'h0000_4000};

   initial begin
      tick();
      tick();
      chk("reset_state", {req_ready, mem_valid, mem_addr, mem_wdata, mem_be, done, misalign},
          {1'b1, 1'b0, 32'h0, 16'h0, 2'b00, 1'b0, 1'b0});
      rst = 1'b0;
      tick();

      // Byte store, odd address.
      drive(1'b1, 2'b00, 32'h0000_1001, 32'h1234_5678);
      mem_ready = 1'b1;
      tick();
      chk("byte_beat", {mem_valid, mem_addr, mem_wdata, mem_be}, {1'b1, 32'h0000_1000, 16'h7878, 2'b01});
      chk("byte_busy", {req_ready, done}, 2'b00);
      req_valid = 1'b0;
      tick();
      chk("byte_done", {done, mem_valid, mem_wdata, mem_be, mem_addr}, {1'b1, 1'b0, 16'h0, 2'b00, 32'h0000_1000});
      tick();
      chk("byte_done_pulse", {done, misalign}, 2'b00);

      // Half store with memory stalled for three cycles.
      drive(1'b1, 2'b01, 32'h0000_2002, 32'hCAFE_BEEF);
      mem_ready = 1'b0;
      tick();
      chk("half_beat", {mem_valid, mem_addr, mem_wdata, mem_be}, {1'b1, 32'h0000_2002, 16'hBEEF, 2'b11});
      drive(1'b0, 2'b00, 32'h0000_7777, 32'h5555_1111);
      for (int i = 0; i < 3; i++) begin
         tick();
         chk("half_hold", {mem_valid, mem_addr, mem_wdata, mem_be, done}, {1'b1, 32'h0000_2002, 16'hBEEF, 2'b11, 1'b0});
      end
      mem_ready = 1'b1;
      tick();
      chk("half_done", {done, mem_valid}, 2'b10);
      tick();
      chk("half_single_done", done, 1'b0);

      // Word store: two beats then done.
      drive(1'b1, 2'b10, 32'h0000_3000, 32'hDEAD_BEEF);
      tick();
      chk("word_beat0", {mem_valid, mem_addr, mem_wdata, mem_be}, {1'b1, 32'h0000_3000, 16'hDEAD, 2'b11});
      req_valid = 1'b0;
      tick();
      chk("word_beat1", {mem_valid, mem_addr, mem_wdata, mem_be, done}, {1'b1, 32'h0000_3002, 16'hBEEF, 2'b11, 1'b0});
      tick();
      chk("word_done", {done, mem_valid}, 2'b10);

      // Word at the top of the address space.
      drive(1'b1, 2'b10, 32'hFFFF_FFFC, 32'h0123_4567);
      tick();
      chk("top_beat0", {mem_addr, mem_wdata}, {32'hFFFF_FFFC, 16'h0123});
      req_valid = 1'b0;
      tick();
      chk("top_beat1", {mem_addr, mem_wdata}, {32'hFFFF_FFFE, 16'h4567});
      tick();
      chk("top_done", done, 1'b1);

      // Rejected requests.
      for (int i = 0; i < 3; i++) begin
         drive(1'b1, mis_sz[i], mis_ad[i], 32'h1111_2222);
         tick();
         chk("misalign_pulse", {misalign, mem_valid, req_ready, done}, 4'b1010);
         req_valid = 1'b0;
         tick();
         chk("misalign_clear", {misalign, mem_valid, req_ready, done}, 4'b0010);
      end

      // Reset during the first beat of a word.
      drive(1'b1, 2'b10, 32'h0000_5000, 32'hA5A5_5A5A);
      mem_ready = 1'b0;
      tick();
      chk("rst_beat0", {mem_valid, mem_addr}, {1'b1, 32'h0000_5000});
      req_valid = 1'b0;
      rst = 1'b1;
      tick();
      chk("rst_drop", {mem_valid, req_ready, done}, 3'b010);
      rst = 1'b0;
      mem_ready = 1'b1;
      tick();
      chk("rst_no_beat1", {mem_valid, req_ready, done}, 3'b010);
      tick();
      chk("rst_no_done", {mem_valid, done}, 2'b00);

      // Back-to-back bytes with req_valid held high.
      drive(1'b1, 2'b00, 32'h0000_0010, 32'h0000_00AB);
      tick();
      chk("b2b_beat0", {mem_valid, mem_be, mem_addr, mem_wdata}, {1'b1, 2'b10, 32'h0000_0010, 16'hABAB});
      req_addr = 32'h0000_0011;
      req_data = 32'h0000_00CD;
      tick();
      chk("b2b_done_ready", {done, req_ready, mem_valid}, 3'b110);
      tick();
      chk("b2b_beat1", {mem_valid, mem_be, mem_addr, mem_wdata}, {1'b1, 2'b01, 32'h0000_0010, 16'hCDCD});
      req_valid = 1'b0;
      tick();
      chk("b2b_done2", done, 1'b1);

      // Randomized traffic against the model.
      for (int i = 0; i < 3000; i++) begin
         req_valid = 1'($urandom_range(0, 1));
         req_size  = 2'($urandom_range(0, 3));
         req_addr  = ($urandom_range(0, 7) == 0) ? (32'hFFFF_FFFC + 32'($urandom_range(0, 3))) : $urandom;
         req_data  = $urandom;
         mem_ready = ($urandom_range(0, 3) != 0);
         rst       = ($urandom_range(0, 149) == 0);
         tick();
      end
      rst = 1'b0;
      req_valid = 1'b0;
      mem_ready = 1'b1;
      repeat (6) tick();

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
